// File: rtl/perreg_capture.sv
// rtl/perreg_capture.sv - sticky per-lane parity error capture with first-index, event count, irq and clear handshake
module perreg_capture #(
    parameter int WIDTH    = 16,
    parameter int CNT_W    = 8,
    parameter int IRQ_MODE = 0,
    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             perr_valid,
    input  logic [WIDTH-1:0] perr,
    input  logic [WIDTH-1:0] mask,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic [WIDTH-1:0] q,
    output logic [IDX_W-1:0] first_idx,
    output logic             first_vld,
    output logic [CNT_W-1:0] err_cnt,
    output logic             cnt_sat,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERR   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] evbits;
    logic             ev;
    logic [IDX_W-1:0] low_idx;
    logic             enter_clear;

    logic [WIDTH-1:0] q_base;
    logic [CNT_W-1:0] cnt_base;
    logic             fv_base;
    logic [IDX_W-1:0] fi_base;

    logic [WIDTH-1:0] q_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             fv_nxt;
    logic [IDX_W-1:0] fi_nxt;
    logic             irq_nxt;

    // Qualified error event: only unmasked lanes with a valid strobe count
    always_comb begin
        evbits = perr & ~mask;
        ev     = perr_valid & (|evbits);
    end

    // Priority encoder: lowest set lane of the current event
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (evbits[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // State register; reset also drops clr_ack through the output register below
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; leaving CLEAR looks at the post-update flags so IDLE always means Q==0
    always_comb begin
        state_nxt   = state;
        enter_clear = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_nxt   = S_CLEAR;
                    enter_clear = 1'b1;
                end else if (ev) begin
                    state_nxt = S_ERR;
                end
            end
            S_ERR: begin
                if (clr_req) begin
                    state_nxt   = S_CLEAR;
                    enter_clear = 1'b1;
                end
            end
            S_CLEAR: begin
                if (!clr_req) begin
                    state_nxt = (q_nxt != '0) ? S_ERR : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath next values: the clear wipes the old history first, then a same-cycle event is applied on top
    always_comb begin
        q_base   = enter_clear ? '0 : q;
        cnt_base = enter_clear ? '0 : err_cnt;
        fv_base  = enter_clear ? 1'b0 : first_vld;
        fi_base  = enter_clear ? '0 : first_idx;

        q_nxt    = q_base;
        cnt_nxt  = cnt_base;
        fv_nxt   = fv_base;
        fi_nxt   = fi_base;

        if (ev) begin
            q_nxt = q_base | evbits;
            if (cnt_base != {CNT_W{1'b1}}) begin
                cnt_nxt = cnt_base + CNT_W'(1);
            end
            if (!fv_base) begin
                fv_nxt = 1'b1;
                fi_nxt = low_idx;
            end
        end

        if (state_nxt == S_CLEAR) begin
            irq_nxt = 1'b0;
        end else if (IRQ_MODE == 0) begin
            irq_nxt = (q_nxt != '0);
        end else begin
            irq_nxt = ev;
        end
    end

    // Output registers, all updated one cycle after the sampled event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            first_idx <= '0;
            first_vld <= 1'b0;
            err_cnt   <= '0;
            cnt_sat   <= 1'b0;
            irq       <= 1'b0;
            clr_ack   <= 1'b0;
        end else begin
            q         <= q_nxt;
            first_idx <= fi_nxt;
            first_vld <= fv_nxt;
            err_cnt   <= cnt_nxt;
            cnt_sat   <= (cnt_nxt == {CNT_W{1'b1}});
            irq       <= irq_nxt;
            clr_ack   <= (state_nxt == S_CLEAR);
        end
    end

endmodule

// File: tb/tb_perreg_capture.sv
// tb/tb_perreg_capture.sv - directed bench with reference model for perreg_capture in two configurations
module tb_perreg_capture;

    logic        clk;
    logic        rst_n;
    logic        perr_valid;
    logic [15:0] perr;
    logic [15:0] mask;
    logic        clr_req;

    logic        clr_ack_a, clr_ack_b;
    logic [15:0] q_a, q_b;
    logic [3:0]  first_idx_a, first_idx_b;
    logic        first_vld_a, first_vld_b;
    logic [7:0]  err_cnt_a;
    logic [1:0]  err_cnt_b;
    logic        cnt_sat_a, cnt_sat_b;
    logic        irq_a, irq_b;

    int total = 0;
    int bad   = 0;

    perreg_capture #(.WIDTH(16), .CNT_W(8), .IRQ_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .perr_valid(perr_valid), .perr(perr), .mask(mask),
        .clr_req(clr_req), .clr_ack(clr_ack_a), .q(q_a), .first_idx(first_idx_a),
        .first_vld(first_vld_a), .err_cnt(err_cnt_a), .cnt_sat(cnt_sat_a), .irq(irq_a)
    );

    perreg_capture #(.WIDTH(16), .CNT_W(2), .IRQ_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .perr_valid(perr_valid), .perr(perr), .mask(mask),
        .clr_req(clr_req), .clr_ack(clr_ack_b), .q(q_b), .first_idx(first_idx_b),
        .first_vld(first_vld_b), .err_cnt(err_cnt_b), .cnt_sat(cnt_sat_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sticky flags, first lane, per-config saturating counts, clear-in-progress flag
    logic [15:0] m_q;
    logic        m_fv;
    int          m_fi;
    int          m_cnt_a, m_cnt_b;
    logic        m_clearing;
    logic        m_irq_a, m_irq_b;

    task automatic model_reset();
        m_q = '0; m_fv = 1'b0; m_fi = 0; m_cnt_a = 0; m_cnt_b = 0;
        m_clearing = 1'b0; m_irq_a = 1'b0; m_irq_b = 1'b0;
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    initial model_reset();
    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        logic [15:0] evb;
        logic        ev;
        if (!rst_n) begin
            model_reset();
        end else begin
            evb = perr & ~mask;
            ev  = perr_valid && (evb != 16'h0);
            if (!m_clearing && clr_req) begin
                m_q = '0; m_fv = 1'b0; m_fi = 0; m_cnt_a = 0; m_cnt_b = 0;
            end
            if (ev) begin
                m_q = m_q | evb;
                m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
                m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
                if (!m_fv) begin
                    m_fv = 1'b1;
                    m_fi = lowest(evb);
                end
            end
            m_clearing = clr_req;
            m_irq_a = !m_clearing && (m_q != 16'h0);
            m_irq_b = !m_clearing && ev;
        end
        #1;
        chk("q_a", q_a, m_q);
        chk("q_b", q_b, m_q);
        chk("first_vld_a", first_vld_a, m_fv);
        chk("first_vld_b", first_vld_b, m_fv);
        chk("first_idx_a", first_idx_a, m_fi);
        chk("first_idx_b", first_idx_b, m_fi);
        chk("err_cnt_a", err_cnt_a, m_cnt_a);
        chk("err_cnt_b", err_cnt_b, m_cnt_b);
        chk("cnt_sat_a", cnt_sat_a, m_cnt_a == 255);
        chk("cnt_sat_b", cnt_sat_b, m_cnt_b == 3);
        chk("irq_a", irq_a, m_irq_a);
        chk("irq_b", irq_b, m_irq_b);
        chk("clr_ack_a", clr_ack_a, m_clearing);
        chk("clr_ack_b", clr_ack_b, m_clearing);
    end

    task automatic cyc(input logic v, input logic [15:0] p, input logic [15:0] m, input logic r);
        @(negedge clk);
        perr_valid = v; perr = p; mask = m; clr_req = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        int exp_sat [5] = '{0, 0, 1, 1, 1};

        rst_n = 1'b0; perr_valid = 1'b0; perr = '0; mask = '0; clr_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            perr_valid = 1'($urandom); perr = 16'($urandom); clr_req = 1'($urandom);
        end
        @(posedge clk); #2;
        chk("lit_rst_q", q_a, 16'h0);
        chk("lit_rst_ack", clr_ack_a, 1'b0);
        chk("lit_rst_cnt", err_cnt_b, 2'd0);
        @(negedge clk);
        rst_n = 1'b1; perr_valid = 1'b0; perr = '0; clr_req = 1'b0;
        cyc(0, 16'h0, 16'h0, 0);
        chk("lit_idle_q", q_a, 16'h0);
        chk("lit_idle_irq", irq_a, 1'b0);

        // accumulation and first-lane capture
        cyc(1, 16'h0120, 16'h0, 0);
        chk("lit_acc_q1", q_a, 16'h0120);
        chk("lit_acc_fi1", first_idx_a, 4'd5);
        chk("lit_acc_cnt1", err_cnt_a, 8'd1);
        chk("lit_acc_irq1", irq_a, 1'b1);
        chk("lit_acc_irqb1", irq_b, 1'b1);
        cyc(1, 16'h0001, 16'h0, 0);
        chk("lit_acc_q2", q_a, 16'h0121);
        chk("lit_acc_fi2", first_idx_a, 4'd5);
        chk("lit_acc_cnt2", err_cnt_a, 8'd2);
        cyc(0, 16'h0, 16'h0, 0);
        chk("lit_lvl_irqa", irq_a, 1'b1);
        chk("lit_pulse_irqb", irq_b, 1'b0);

        // clear, then mask and valid qualification
        cyc(0, 16'h0, 16'h0, 1);
        cyc(0, 16'h0, 16'h0, 0);
        cyc(1, 16'h8000, 16'hFFFE, 0);
        chk("lit_mask_q", q_a, 16'h0);
        chk("lit_mask_cnt", err_cnt_a, 8'd0);
        cyc(0, 16'h0001, 16'hFFFE, 0);
        chk("lit_nv_q", q_a, 16'h0);
        cyc(1, 16'h0001, 16'hFFFE, 0);
        chk("lit_unmask_q", q_a, 16'h0001);
        chk("lit_unmask_fi", first_idx_a, 4'd0);
        cyc(0, 16'h0, 16'h0000, 0);
        chk("lit_mask_keep", q_a, 16'h0001);

        // saturation of the 2-bit counter
        cyc(0, 16'h0, 16'h0, 1);
        cyc(0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 16'h0001 << i, 16'h0, 0);
            chk("lit_sat_cnt", err_cnt_b, exp_cnt[i]);
            chk("lit_sat_flag", cnt_sat_b, exp_sat[i]);
        end

        // clear handshake with Q=00FF
        cyc(0, 16'h0, 16'h0, 1);
        cyc(0, 16'h0, 16'h0, 0);
        cyc(1, 16'h00FF, 16'h0, 0);
        chk("lit_clr_pre", q_a, 16'h00FF);
        cyc(0, 16'h0, 16'h0, 1);
        chk("lit_clr_ack", clr_ack_a, 1'b1);
        chk("lit_clr_q", q_a, 16'h0);
        chk("lit_clr_irq", irq_a, 1'b0);
        repeat (2) cyc(0, 16'h0, 16'h0, 1);
        chk("lit_clr_hold", clr_ack_a, 1'b1);
        cyc(0, 16'h0, 16'h0, 0);
        chk("lit_clr_drop", clr_ack_a, 1'b0);
        chk("lit_clr_idle_irq", irq_a, 1'b0);

        // clear with a same-cycle event that survives, plus an event inside CLEAR
        cyc(1, 16'h00FF, 16'h0, 0);
        cyc(1, 16'h0400, 16'h0, 1);
        chk("lit_surv_q", q_a, 16'h0400);
        chk("lit_surv_cnt", err_cnt_a, 8'd1);
        chk("lit_surv_fi", first_idx_a, 4'd10);
        chk("lit_surv_irq", irq_a, 1'b0);
        cyc(1, 16'h0002, 16'h0, 1);
        chk("lit_in_clr_q", q_a, 16'h0402);
        chk("lit_in_clr_cnt", err_cnt_a, 8'd2);
        chk("lit_in_clr_irqb", irq_b, 1'b0);
        cyc(0, 16'h0, 16'h0, 0);
        chk("lit_exit_ack", clr_ack_a, 1'b0);
        chk("lit_exit_irq", irq_a, 1'b1);

        // pulse-mode irq: two events three cycles apart
        cyc(1, 16'h0010, 16'h0, 0);
        chk("lit_p1", irq_b, 1'b1);
        cyc(0, 16'h0, 16'h0, 0);
        chk("lit_p1_end", irq_b, 1'b0);
        cyc(0, 16'h0, 16'h0, 0);
        cyc(1, 16'h0010, 16'h0, 0);
        chk("lit_p2", irq_b, 1'b1);
        cyc(0, 16'h0, 16'h0, 0);
        chk("lit_p2_end", irq_b, 1'b0);

        // async reset in the middle of a clear
        cyc(0, 16'h0, 16'h0, 1);
        chk("lit_mid_ack", clr_ack_b, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_async_ack_a", clr_ack_a, 1'b0);
        chk("lit_async_ack_b", clr_ack_b, 1'b0);
        chk("lit_async_q", q_a, 16'h0);
        @(negedge clk);
        rst_n = 1'b1; clr_req = 1'b0;
        cyc(0, 16'h0, 16'h0, 0);
        cyc(1, 16'h0008, 16'h0, 0);
        chk("lit_post_rst_fi", first_idx_a, 4'd3);
        cyc(0, 16'h0, 16'h0, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
